// File: rtl/bram_rd_streamer_pkg.sv
// rtl/bram_rd_streamer_pkg.sv - shared FSM state type and parameter legality checks
package bram_rd_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic bit rd_latency_ok(input int rd_latency);
      return (rd_latency == 1) || (rd_latency == 2);
   endfunction

   function automatic bit fifo_depth_ok(input int fifo_depth, input int rd_latency);
      return (fifo_depth >= rd_latency + 1) && ((fifo_depth & (fifo_depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/bram_rd_streamer_sync_fifo.sv
// rtl/bram_rd_streamer_sync_fifo.sv - register FIFO with occupancy count, head word shown combinationally
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage is cleared on reset so the head word reads as zero while empty.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(wr_en) - CNT_W'(do_rd);
      end
   end

endmodule

// File: rtl/bram_rd_streamer.sv
// rtl/bram_rd_streamer.sv - streams a burst of BRAM words out through a credit-limited buffer
module bram_rd_streamer
   import bram_rd_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_en,
   output logic                  bram_regce,
   output logic                  bram_rst,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
      $error("RD_LATENCY must be 1 or 2");
   end
   if (!fifo_depth_ok(FIFO_DEPTH, RD_LATENCY)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least RD_LATENCY+1");
   end

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic [ADDR_WIDTH:0]   issued;
   logic [ADDR_WIDTH:0]   delivered;
   logic [RD_LATENCY-1:0] vld_sr;
   logic [CNT_W-1:0]      inflight;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W:0]        occupancy;
   logic                  fifo_empty;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  last_word;
   logic                  zero_done;

   assign push       = vld_sr[RD_LATENCY-1];
   assign m_valid    = !fifo_empty;
   assign pop        = m_valid && m_ready;
   assign last_word  = (delivered == len_q - (ADDR_WIDTH + 1)'(1));
   assign m_last     = m_valid && last_word;
   assign busy       = (state != IDLE);
   assign done       = zero_done || ((state == DRAIN) && pop && m_last);
   assign bram_en    = issue;
   assign bram_addr  = base_q + issued[ADDR_WIDTH-1:0];
   assign bram_regce = 1'b1;
   assign bram_rst   = 1'b0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A pop this cycle frees a slot, so it counts as credit for an issue in the same cycle.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      occupancy = {1'b0, inflight} + {1'b0, fifo_count} - (CNT_W + 1)'(pop);
      unique case (state)
         IDLE: begin
            if (start && (len != '0)) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            issue = (issued < len_q) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
            if ((issued + (ADDR_WIDTH + 1)'(issue)) == len_q) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && m_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         base_q    <= '0;
         len_q     <= '0;
         issued    <= '0;
         delivered <= '0;
         inflight  <= '0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= (state == IDLE) && start && (len == '0);
         if ((state == IDLE) && start) begin
            base_q    <= base_addr;
            len_q     <= len;
            issued    <= '0;
            delivered <= '0;
         end else begin
            if (issue) begin
               issued <= issued + (ADDR_WIDTH + 1)'(1);
            end
            if (pop) begin
               delivered <= delivered + (ADDR_WIDTH + 1)'(1);
            end
         end
         inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
      end
   end

   // Each tag reaches the last stage in the cycle its BRAM word is on bram_dout.
   if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            vld_sr <= '0;
         end else begin
            vld_sr <= issue;
         end
      end
   end else begin : g_latn
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            vld_sr <= '0;
         end else begin
            vld_sr <= {vld_sr[RD_LATENCY-2:0], issue};
         end
      end
   end

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (push),
      .wr_data (bram_dout),
      .rd_en   (pop),
      .rd_data (m_data),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: doc/bram_rd_streamer.md
BRAM_RD_STREAMER -- requirements
Module: bram_rd_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the read data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9, giving the BRAM address width.
REQ-003 The block SHALL have parameter RD_LATENCY, default 2, giving the BRAM read latency in cycles (legal values 1 or 2).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output buffer depth; it shall be at least RD_LATENCY+1 and a power of two.
REQ-005 Port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 Port rstn, input, width 1: reset, asynchronous, active-low.
REQ-007 Port start, input, width 1: request a burst; sampled only in IDLE.
REQ-008 Port base_addr, input, width ADDR_WIDTH: first word address, captured with start.
REQ-009 Port len, input, width ADDR_WIDTH+1: number of words in the burst, captured with start.
REQ-010 Port busy, output, width 1: high whenever the state is not IDLE.
REQ-011 Port done, output, width 1: one-cycle pulse at burst completion.
REQ-012 Port bram_addr, output, width ADDR_WIDTH: BRAM read address.
REQ-013 Port bram_en, output, width 1: BRAM read enable.
REQ-014 Port bram_regce, output, width 1: BRAM output register enable, driven constant 1.
REQ-015 Port bram_rst, output, width 1: BRAM output register reset, driven constant 0.
REQ-016 Port bram_dout, input, width DATA_WIDTH: BRAM read data.
REQ-017 Port m_data, output, width DATA_WIDTH: stream data.
REQ-018 Port m_valid, output, width 1: stream data valid.
REQ-019 Port m_ready, input, width 1: consumer ready.
REQ-020 Port m_last, output, width 1: marks the final word of the burst.

Function
REQ-021 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-022 IDLE->ISSUE SHALL occur on start=1 with len!=0; start=1 with len=0 SHALL stay in IDLE, pulse done the next cycle and issue no reads.
REQ-023 In ISSUE, bram_en SHALL be 1 only when issued<len and inflight+fifo_count<FIFO_DEPTH (credit rule), so the buffer never overflows.
REQ-024 bram_addr SHALL equal (base_addr+issued) mod 2^ADDR_WIDTH, so the address wraps silently past the top of memory.
REQ-025 A valid shift register of length RD_LATENCY SHALL tag each issued read, and bram_dout SHALL be written to the FIFO exactly RD_LATENCY cycles after its bram_en.
REQ-026 ISSUE->DRAIN SHALL occur when issued reaches len.
REQ-027 DRAIN->IDLE SHALL occur on the handshake (m_valid&m_ready) of the last word; done SHALL pulse in that same cycle.
REQ-028 m_valid SHALL be 1 whenever the FIFO is non-empty, and m_data/m_valid/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-029 m_last SHALL be 1 only on the word whose sequence index is len-1.
REQ-030 A FIFO write and read in the same cycle SHALL leave the count unchanged; a pop and a credit release in the same cycle SHALL allow a new issue in that cycle.
REQ-031 With m_ready held at 1, throughput SHALL be one word per cycle after an initial latency of RD_LATENCY+1 cycles from start to the first m_valid.
REQ-032 start SHALL be ignored while busy=1.

Reset
REQ-033 While rstn=0, the block SHALL set state=IDLE, busy=0, done=0, bram_en=0, bram_addr=0, m_valid=0, m_last=0 and m_data=0, and SHALL clear the FIFO, the counters and the in-flight tags.
REQ-034 Reset asserted mid-burst SHALL discard all in-flight data; data returning after reset release SHALL NOT be written to the FIFO.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the FIFO_DEPTH/RD_LATENCY legality checks.
REQ-036 The output buffer SHALL be a sub-module named sync_fifo (a parameterised width/depth register FIFO with count output).

Verification
REQ-037 Scenario: base=0x010, len=8, m_ready=1 -> words 0x010..0x017 appear in order on consecutive cycles, the first m_valid 3 cycles after start, m_last on the 8th word, done with that word.
REQ-038 Scenario: base=0x1FE, len=4 -> addresses 0x1FE, 0x1FF, 0x000, 0x001.
REQ-039 Scenario: len=16, m_ready=0 for 20 cycles -> exactly FIFO_DEPTH reads issued, no data lost; releasing m_ready delivers all 16 in order.
REQ-040 Scenario: m_ready toggling 1/0 each cycle, len=10 -> 10 words delivered in order, m_data stable during stalls.
REQ-041 Scenario: start with len=0 -> bram_en never asserted, done pulses one cycle later, busy stays 0.
REQ-042 Scenario: rstn pulsed low after 3 of 8 words delivered -> outputs are zero immediately, and a new start with len=2 yields exactly 2 correct words.
